wasm_host_sequencer: RTL and testbench

- Host-side controller that drives a full WASM_TOP run: load, wait, read back.
- Packs a byte stream into 64-bit words and writes them to the core's instruction memory.
- Asserts the write-finish strobe, then measures run cycles until the core reports done (work_state 2'b11).
- Reads a fixed list of line-memory words (globals, then out_mem) and streams them out over a 32-bit valid/ready port.

---
 rtl/wasm_host_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_wasm_host_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_host_sequencer.sv
// wasm_host_sequencer: host-side driver for a complete WASM_TOP run.
// Packs a program byte stream into 64-bit instruction words and writes them to the core.
// Raises the write-finish level and counts run cycles until the core reports done.
// Reads back the global words and then the out_mem words over a 32-bit result stream.
//
// Every handshake in this block (byte in, instruction write, result out) uses the same rule.
// A transfer happens on a rising clock edge where valid and ready are both high.
// Once the sender raises valid, it holds valid and its payload stable until that transfer.
`timescale 1ns/1ps
module wasm_host_sequencer #(
    parameter int         N_GLOBAL    = 10,
    parameter logic [8:0] GLOBAL_BASE = 9'h100,
    parameter int         N_OUT       = 10,
    parameter logic [8:0] OUT_BASE    = 9'h000,
    parameter int         MAX_WORDS   = 32768,
    parameter int         TIMEOUT     = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    output logic        o_byte_rdy,
    output logic        o_instr_mem_wr_vld,
    output logic [14:0] o_instr_mem_wr_addr,
    output logic [63:0] o_instr_mem_wr_data,
    input  logic        i_instr_mem_wr_rdy,
    output logic        o_instr_mem_wr_finish,
    input  logic [1:0]  i_work_state,
    input  logic [2:0]  i_error,
    output logic        o_line_mem_rd_rdy,
    output logic [8:0]  o_line_mem_rd_addr,
    input  logic [31:0] i_line_mem_rd_data,
    output logic        o_res_vld,
    output logic [31:0] o_res_data,
    output logic        o_res_last,
    input  logic        i_res_rdy,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err_code,
    output logic [31:0] o_cycle_cnt,
    output logic [2:0]  o_dbg_state
);

    localparam int N_RES = N_GLOBAL + N_OUT;
    localparam int IDX_W = $clog2(N_RES + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_READ = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Read-back sub-phase: address cycle, data-capture cycle, result held for the consumer.
    typedef enum logic [1:0] {
        RD_ADDR = 2'd0,
        RD_CAP  = 2'd1,
        RD_HOLD = 2'd2
    } rd_phase_t;

    state_t     state;
    rd_phase_t  rd_phase;
    logic [63:0]      word_buf;
    logic [2:0]       byte_idx;
    logic             pending;
    logic             word_last;
    logic [15:0]      word_cnt;
    logic [IDX_W-1:0] rd_idx;
    logic [8:0]       rd_addr;
    logic             full;

    // Line-memory address of result word idx: globals come first, then out_mem.
    function automatic logic [8:0] res_addr(input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(N_GLOBAL))
            res_addr = GLOBAL_BASE + 9'(idx);
        else
            res_addr = OUT_BASE + 9'(idx - IDX_W'(N_GLOBAL));
    endfunction

    assign full                  = (word_cnt == 16'(MAX_WORDS));
    assign o_byte_rdy            = (state == S_LOAD) && !pending && !full;
    assign o_instr_mem_wr_vld    = pending;
    assign o_instr_mem_wr_addr   = word_cnt[14:0];
    assign o_instr_mem_wr_data   = word_buf;
    assign o_instr_mem_wr_finish = (state == S_RUN);
    assign o_line_mem_rd_rdy     = (state == S_READ);
    assign o_line_mem_rd_addr    = rd_addr;
    assign o_busy                = (state == S_LOAD) || (state == S_RUN) || (state == S_READ);
    assign o_dbg_state           = state;

    // Sequencer: load, run, read back, with a fault exit from any active phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            rd_phase    <= RD_ADDR;
            word_buf    <= '0;
            byte_idx    <= '0;
            pending     <= 1'b0;
            word_last   <= 1'b0;
            word_cnt    <= '0;
            rd_idx      <= '0;
            rd_addr     <= '0;
            o_res_vld   <= 1'b0;
            o_res_data  <= '0;
            o_res_last  <= 1'b0;
            o_done      <= 1'b0;
            o_err_code  <= 2'd0;
            o_cycle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        state       <= S_LOAD;
                        o_done      <= 1'b0;
                        o_err_code  <= 2'd0;
                        o_cycle_cnt <= '0;
                        word_cnt    <= '0;
                        rd_idx      <= '0;
                        word_buf    <= '0;
                        byte_idx    <= '0;
                        pending     <= 1'b0;
                        word_last   <= 1'b0;
                        rd_phase    <= RD_ADDR;
                    end
                end
                S_LOAD: begin
                    if (pending) begin
                        if (i_instr_mem_wr_rdy) begin
                            pending  <= 1'b0;
                            word_buf <= '0;
                            word_cnt <= word_cnt + 16'd1;
                            if (word_last) begin
                                state       <= S_RUN;
                                o_cycle_cnt <= '0;
                            end
                        end
                    end else if (i_byte_vld) begin
                        if (full) begin
                            // The byte stays with the producer; the program does not fit.
                            state      <= S_ERR;
                            o_err_code <= 2'd3;
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= i_byte_data;
                            if (byte_idx == 3'd7 || i_byte_last) begin
                                pending   <= 1'b1;
                                word_last <= i_byte_last;
                                byte_idx  <= '0;
                            end else begin
                                byte_idx <= byte_idx + 3'd1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (i_error != 3'd0) begin
                        state      <= S_ERR;
                        o_err_code <= 2'd1;
                    end else if (i_work_state == 2'b11) begin
                        state    <= S_READ;
                        rd_idx   <= '0;
                        rd_addr  <= res_addr(IDX_W'(0));
                        rd_phase <= RD_ADDR;
                    end else if (o_cycle_cnt == 32'(TIMEOUT)) begin
                        state      <= S_ERR;
                        o_err_code <= 2'd2;
                    end else begin
                        o_cycle_cnt <= o_cycle_cnt + 32'd1;
                    end
                end
                S_READ: begin
                    case (rd_phase)
                        RD_ADDR: rd_phase <= RD_CAP;
                        RD_CAP: begin
                            o_res_data <= i_line_mem_rd_data;
                            o_res_vld  <= 1'b1;
                            o_res_last <= (rd_idx == IDX_W'(N_RES - 1));
                            rd_idx     <= rd_idx + IDX_W'(1);
                            // The next address is presented while this result waits for its accept.
                            if (rd_idx != IDX_W'(N_RES - 1))
                                rd_addr <= res_addr(rd_idx + IDX_W'(1));
                            rd_phase <= RD_HOLD;
                        end
                        RD_HOLD: begin
                            if (i_res_rdy) begin
                                o_res_vld  <= 1'b0;
                                o_res_last <= 1'b0;
                                if (o_res_last) begin
                                    state  <= S_DONE;
                                    o_done <= 1'b1;
                                end else begin
                                    rd_phase <= RD_CAP;
                                end
                            end
                        end
                        default: rd_phase <= RD_ADDR;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wasm_host_sequencer.sv
// Self-checking bench for wasm_host_sequencer.
// A behavioural model drives the core and line memory and predicts the write and result streams.
`timescale 1ns/1ps
module tb_wasm_host_sequencer;
  localparam int         N_GLOBAL    = 10;
  localparam logic [8:0] GLOBAL_BASE = 9'h100;
  localparam int         N_OUT       = 10;
  localparam logic [8:0] OUT_BASE    = 9'h000;
  localparam int         N_RES       = N_GLOBAL + N_OUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        byte_vld = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_last = 1'b0;
  logic        wr_rdy = 1'b1;
  logic [1:0]  work_state = 2'b00;
  logic [2:0]  core_error = 3'b000;
  logic [31:0] line_data = 32'd0;
  logic        res_rdy = 1'b1;

  logic        o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_finish;
  logic [14:0] o_instr_mem_wr_addr;
  logic [63:0] o_instr_mem_wr_data;
  logic        o_line_mem_rd_rdy;
  logic [8:0]  o_line_mem_rd_addr;
  logic        o_res_vld, o_res_last, o_busy, o_done;
  logic [31:0] o_res_data, o_cycle_cnt;
  logic [1:0]  o_err_code;
  logic [2:0]  o_dbg_state;

  wasm_host_sequencer dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_start               (start),
    .i_byte_vld            (byte_vld),
    .i_byte_data           (byte_data),
    .i_byte_last           (byte_last),
    .o_byte_rdy            (o_byte_rdy),
    .o_instr_mem_wr_vld    (o_instr_mem_wr_vld),
    .o_instr_mem_wr_addr   (o_instr_mem_wr_addr),
    .o_instr_mem_wr_data   (o_instr_mem_wr_data),
    .i_instr_mem_wr_rdy    (wr_rdy),
    .o_instr_mem_wr_finish (o_instr_mem_wr_finish),
    .i_work_state          (work_state),
    .i_error               (core_error),
    .o_line_mem_rd_rdy     (o_line_mem_rd_rdy),
    .o_line_mem_rd_addr    (o_line_mem_rd_addr),
    .i_line_mem_rd_data    (line_data),
    .o_res_vld             (o_res_vld),
    .o_res_data            (o_res_data),
    .o_res_last            (o_res_last),
    .i_res_rdy             (res_rdy),
    .o_busy                (o_busy),
    .o_done                (o_done),
    .o_err_code            (o_err_code),
    .o_cycle_cnt           (o_cycle_cnt),
    .o_dbg_state           (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int scen_id = 0;

  int          cfg_delay = 0;
  logic [2:0]  cfg_err = 3'd0;
  bit          cfg_wr_rand = 1'b0;
  int          cfg_stall0 = 0;
  int          cfg_res_mode = 0;
  logic [31:0] cfg_salt = 32'd0;
  bit          cfg_gaps = 1'b0;

  logic [7:0]  prog_q[$];
  logic [14:0] exp_wa_q[$];
  logic [63:0] exp_wd_q[$];
  logic [31:0] exp_res_q[$];
  logic [63:0] wr_log[$];
  logic [31:0] res_log[$];
  int rd_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- environment models ----------------
  // Core: reports done (and the configured error) cfg_delay cycles after finish first rises.
  int   core_seen = 0;
  int   core_cd = -1;
  logic core_prev_fin = 1'b0;
  always @(negedge clk) begin
    if (core_seen != scen_id) begin
      core_seen = scen_id;
      core_cd = -1;
      core_prev_fin = 1'b0;
      work_state = 2'b00;
      core_error = 3'b000;
    end
    if (o_instr_mem_wr_finish && !core_prev_fin) core_cd = cfg_delay;
    core_prev_fin = o_instr_mem_wr_finish;
    if (core_cd == 0) begin
      work_state = 2'b11;
      core_error = cfg_err;
    end
    if (core_cd >= 0) core_cd--;
  end

  // Instruction memory ready: optional forced stall on word 0, otherwise fixed or random.
  int wr_seen = 0;
  int stall_left = 0;
  always @(negedge clk) begin
    if (wr_seen != scen_id) begin
      wr_seen = scen_id;
      stall_left = cfg_stall0;
    end
    if (o_instr_mem_wr_vld && o_instr_mem_wr_addr == 15'd0 && stall_left > 0) begin
      wr_rdy = 1'b0;
      stall_left--;
    end else if (cfg_wr_rand) begin
      wr_rdy = ($urandom_range(0, 2) != 0);
    end else begin
      wr_rdy = 1'b1;
    end
  end

  // Result consumer: 0 = always ready, 1 = random, 2 = never ready.
  always @(negedge clk) begin
    case (cfg_res_mode)
      1:       res_rdy = ($urandom_range(0, 1) != 0);
      2:       res_rdy = 1'b0;
      default: res_rdy = 1'b1;
    endcase
  end

  // Line memory: data for an address appears in the following cycle, value = salt ^ address.
  logic [8:0] lm_prev_addr = 9'd0;
  always @(negedge clk) begin
    line_data = cfg_salt ^ {23'd0, lm_prev_addr};
    lm_prev_addr = o_line_mem_rd_addr;
  end

  // ---------------- compare process ----------------
  logic        m_pv_vld = 1'b0, m_pv_rdy = 1'b0, m_pv_fin = 1'b0;
  logic [14:0] m_pv_addr = 15'd0;
  logic [63:0] m_pv_data = 64'd0;
  logic        m_pr_vld = 1'b0, m_pr_rdy = 1'b0, m_pr_last = 1'b0;
  logic [31:0] m_pr_data = 32'd0;
  int          last_acc_cyc = 0;
  always @(negedge clk) begin
    logic [14:0] ea;
    logic [63:0] ed;
    logic [31:0] er;
    #1;
    if (rst) begin
      m_pv_vld = 1'b0; m_pv_rdy = 1'b0; m_pv_fin = 1'b0;
      m_pr_vld = 1'b0; m_pr_rdy = 1'b0;
    end else begin
      cyc++;
      if (m_pv_vld && !m_pv_rdy) begin
        check("wr_vld_held", o_instr_mem_wr_vld, 1);
        check("wr_addr_held", o_instr_mem_wr_addr, m_pv_addr);
        check("wr_data_held", o_instr_mem_wr_data, m_pv_data);
      end
      if (o_instr_mem_wr_vld) check("byte_rdy_while_pending", o_byte_rdy, 0);
      if (o_instr_mem_wr_vld && wr_rdy) begin
        if (exp_wd_q.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          ea = exp_wa_q.pop_front();
          ed = exp_wd_q.pop_front();
          check("wr_addr", o_instr_mem_wr_addr, ea);
          check("wr_data", o_instr_mem_wr_data, ed);
        end
        wr_log.push_back(o_instr_mem_wr_data);
        last_acc_cyc = cyc;
      end
      if (o_instr_mem_wr_finish && !m_pv_fin) begin
        check("finish_after_last_accept", cyc, last_acc_cyc + 1);
        check("writes_left_at_finish", exp_wd_q.size(), 0);
      end
      if (o_line_mem_rd_rdy) rd_seen++;
      if (m_pr_vld && !m_pr_rdy) begin
        check("res_vld_held", o_res_vld, 1);
        check("res_data_held", o_res_data, m_pr_data);
        check("res_last_held", o_res_last, m_pr_last);
      end
      if (o_res_vld && res_rdy) begin
        if (exp_res_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          check("res_last", o_res_last, exp_res_q.size() == 1);
          er = exp_res_q.pop_front();
          check("res_data", o_res_data, er);
        end
        res_log.push_back(o_res_data);
      end
      m_pv_vld = o_instr_mem_wr_vld; m_pv_rdy = wr_rdy; m_pv_fin = o_instr_mem_wr_finish;
      m_pv_addr = o_instr_mem_wr_addr; m_pv_data = o_instr_mem_wr_data;
      m_pr_vld = o_res_vld; m_pr_rdy = res_rdy; m_pr_last = o_res_last; m_pr_data = o_res_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bytes();
    int w;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (cfg_gaps && $urandom_range(0, 3) == 0) begin
        byte_vld = 1'b0;
        @(negedge clk);
      end
      byte_vld = 1'b1;
      byte_data = prog_q[i];
      byte_last = (i == prog_q.size() - 1);
      w = 0;
      while (!o_byte_rdy && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (w >= 300) begin
        fail_now("byte_accept_timeout");
        break;
      end
      @(negedge clk);
    end
    byte_vld = 1'b0;
    byte_last = 1'b0;
  endtask

  // Builds the expected streams from the program and result-address rules, then starts a run.
  task automatic start_seq(input int n, input bit incr, input int delay, input logic [2:0] err);
    logic [63:0] word;
    int k;
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(incr ? 8'(i) : 8'($urandom_range(0, 255)));
    exp_wa_q.delete(); exp_wd_q.delete(); exp_res_q.delete();
    for (int w = 0; w < (n + 7) / 8; w++) begin
      word = 64'd0;
      for (int b = 0; b < 8; b++) begin
        k = 8 * w + b;
        if (k < n) word = word | (64'(prog_q[k]) << (8 * b));
      end
      exp_wa_q.push_back(15'(w));
      exp_wd_q.push_back(word);
    end
    if (err == 3'd0) begin
      for (int i = 0; i < N_GLOBAL; i++) exp_res_q.push_back(cfg_salt ^ (32'(GLOBAL_BASE) + 32'(i)));
      for (int i = 0; i < N_OUT; i++) exp_res_q.push_back(cfg_salt ^ (32'(OUT_BASE) + 32'(i)));
    end
    wr_log.delete(); res_log.delete(); rd_seen = 0;
    cfg_delay = delay; cfg_err = err;
    @(negedge clk); scen_id++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_bytes();
  endtask

  task automatic finish_seq();
    int w = 0;
    while (o_busy && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now("sequence_timeout");
    @(negedge clk);
  endtask

  task automatic check_end(input string tag, input int delay, input logic [1:0] code);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, code == 2'd0);
    check({tag, "_err_code"}, o_err_code, code);
    check({tag, "_cycle_cnt"}, o_cycle_cnt, delay);
    check({tag, "_writes_left"}, exp_wd_q.size(), 0);
    check({tag, "_results_left"}, exp_res_q.size(), 0);
    check({tag, "_result_count"}, res_log.size(), (code == 2'd0) ? N_RES : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {o_byte_rdy, o_instr_mem_wr_vld, o_instr_mem_wr_finish, o_line_mem_rd_rdy,
                           o_res_vld, o_res_last, o_busy, o_done}, 0);
    check({tag, "_wr_addr"}, o_instr_mem_wr_addr, 0);
    check({tag, "_wr_data"}, o_instr_mem_wr_data, 0);
    check({tag, "_rd_addr"}, o_line_mem_rd_addr, 0);
    check({tag, "_res_data"}, o_res_data, 0);
    check({tag, "_err_code"}, o_err_code, 0);
    check({tag, "_cycle_cnt"}, o_cycle_cnt, 0);
    check({tag, "_state"}, o_dbg_state, 0);
  endtask

  // ---------------- main sequence and final report ----------------
  initial begin
    int n, d, w;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // 16 incrementing bytes, core done 123 cycles after finish, address-valued line memory.
    start_seq(16, 1'b1, 123, 3'd0);
    finish_seq();
    check_end("seq16", 123, 2'd0);
    check("seq16_word0", wr_log[0], 64'h0706050403020100);
    check("seq16_word1", wr_log[1], 64'h0F0E0D0C0B0A0908);
    check("seq16_res_first", 64'(res_log[0]), 64'h100);
    check("seq16_res_g9", 64'(res_log[9]), 64'h109);
    check("seq16_res_o0", 64'(res_log[10]), 64'h0);
    check("seq16_res_last", 64'(res_log[19]), 64'h9);

    // 11 bytes with word 0 held off for 5 cycles.
    cfg_stall0 = 5;
    start_seq(11, 1'b1, 7, 3'd0);
    finish_seq();
    check_end("seq11", 7, 2'd0);
    check("seq11_word0", wr_log[0], 64'h0706050403020100);
    check("seq11_word1", wr_log[1], 64'h00000000000A0908);
    cfg_stall0 = 0;

    // Randomized programs, stalls on both handshakes, gaps on the byte stream.
    for (int r = 0; r < 8; r++) begin
      cfg_wr_rand = 1'b1; cfg_res_mode = 1; cfg_gaps = 1'b1;
      cfg_salt = $urandom;
      n = $urandom_range(1, 40);
      d = $urandom_range(0, 60);
      start_seq(n, 1'b0, d, 3'd0);
      finish_seq();
      check_end("random", d, 2'd0);
    end

    // Core error in the same cycle as done: error wins, nothing is read.
    cfg_wr_rand = 1'b0; cfg_res_mode = 0; cfg_gaps = 1'b0; cfg_salt = 32'd0;
    start_seq(5, 1'b0, 20, 3'b010);
    finish_seq();
    check_end("core_err", 20, 2'd1);
    check("core_err_no_reads", rd_seen, 0);

    // Asynchronous reset in the middle of read-back with the consumer stalled.
    cfg_res_mode = 2;
    start_seq(16, 1'b1, 10, 3'd0);
    w = 0;
    while (!o_res_vld && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) fail_now("wait_first_result");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_read_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_wa_q.delete(); exp_wd_q.delete(); exp_res_q.delete();

    // Clean reload after the reset must start again at word address 0.
    cfg_res_mode = 0; cfg_wr_rand = 1'b1;
    start_seq(9, 1'b0, 15, 3'd0);
    finish_seq();
    check_end("reload", 15, 2'd0);
    check("reload_words", wr_log.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
